// File: rtl/pru_pkg.sv
// Shared types for the PRU command scheduler:
// command bundle, shape codes and scheduler states.
package pru_pkg;

  typedef struct packed {
    logic [1:0]  color;
    logic [9:0]  row;
    logic [8:0]  col;
    logic [9:0]  width;
    logic [8:0]  height_radius;
    logic [1:0]  shape_select;
    logic        subtract;
    logic [31:0] bitmap_addr;
  } pru_cmd_t;

  localparam logic [1:0] SHAPE_RECT   = 2'b00;
  localparam logic [1:0] SHAPE_CIRCLE = 2'b01;

  typedef enum logic [1:0] {
    S_IDLE,
    S_ISSUE,
    S_WAIT_DONE,
    S_RELEASE
  } sched_state_t;

endpackage

// File: rtl/pru_cmd_fifo.sv
// Per-requester synchronous command FIFO.
// Head entry is visible on dout whenever not empty.
module pru_cmd_fifo
  import pru_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic     clk,
  input  logic     rst,
  input  logic     push,
  input  pru_cmd_t din,
  input  logic     pop,
  output pru_cmd_t dout,
  output logic     full,
  output logic     empty
);

  localparam int AW = $clog2(DEPTH);

  pru_cmd_t     r_mem [DEPTH];
  logic [AW:0]  r_wr;
  logic [AW:0]  r_rd;
  logic         w_push;
  logic         w_pop;

  assign w_push = push && !full;
  assign w_pop  = pop && !empty;

  // Extra pointer bit separates full from empty.
  assign empty = (r_wr == r_rd);
  assign full  = (r_wr[AW] != r_rd[AW]) &&
                 (r_wr[AW-1:0] == r_rd[AW-1:0]);
  assign dout  = r_mem[r_rd[AW-1:0]];

  always_ff @(posedge clk) begin
    if (rst) begin
      r_wr <= '0;
      r_rd <= '0;
    end else begin
      if (w_push) r_wr <= r_wr + 1'b1;
      if (w_pop)  r_rd <= r_rd + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wr[AW-1:0]] <= din;
  end

endmodule

// File: rtl/pru_sched.sv
// PRU command scheduler: per-requester FIFOs, arbiter, start/done sequencer.
// PRU_SCHED_PRIO_EN selects fixed priority instead of round-robin.
module pru_sched
  import pru_pkg::*;
#(
  parameter  int NUM_REQ = 2,
  parameter  int DEPTH   = 4,
  localparam int IW      = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [NUM_REQ-1:0]      req_valid,
  input  pru_cmd_t [NUM_REQ-1:0]  req_cmd,
  output logic [NUM_REQ-1:0]      req_ready,
  output logic                    pru_start,
  output pru_cmd_t                pru_cmd,
  input  logic                    pru_busy,
  input  logic                    pru_done,
  output logic                    cmp_valid,
  output logic [IW-1:0]           cmp_id,
  output logic                    sched_busy
);

  sched_state_t       r_state;
  sched_state_t       w_next;
  logic [NUM_REQ-1:0] w_empty;
  logic [NUM_REQ-1:0] w_full;
  logic [NUM_REQ-1:0] w_pop;
  pru_cmd_t           w_head [NUM_REQ];
  logic               w_gnt_vld;
  logic [IW-1:0]      w_gnt_id;
  logic [IW-1:0]      r_gnt;
  logic               w_issue;

  for (genvar g = 0; g < NUM_REQ; g++) begin : g_fifo
    pru_cmd_fifo #(.DEPTH(DEPTH)) u_fifo (
      .clk   (clk),
      .rst   (rst),
      .push  (req_valid[g]),
      .din   (req_cmd[g]),
      .pop   (w_pop[g]),
      .dout  (w_head[g]),
      .full  (w_full[g]),
      .empty (w_empty[g])
    );
  end

  assign req_ready  = ~w_full;
  assign sched_busy = !(&w_empty) || (r_state != S_IDLE);

`ifdef PRU_SCHED_PRIO_EN
  always_comb begin
    w_gnt_vld = 1'b0;
    w_gnt_id  = '0;
    for (int k = NUM_REQ - 1; k >= 0; k--) begin
      if (!w_empty[k]) begin
        w_gnt_vld = 1'b1;
        w_gnt_id  = IW'(k);
      end
    end
  end
`else
  logic [IW-1:0] r_last;
  int            v_idx;

  // Walk downward so the nearest requester after r_last wins.
  always_comb begin
    w_gnt_vld = 1'b0;
    w_gnt_id  = '0;
    v_idx     = 0;
    for (int k = NUM_REQ - 1; k >= 0; k--) begin
      v_idx = (int'(r_last) + 1 + k) % NUM_REQ;
      if (!w_empty[v_idx]) begin
        w_gnt_vld = 1'b1;
        w_gnt_id  = IW'(v_idx);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst)          r_last <= IW'(NUM_REQ - 1);
    else if (w_issue) r_last <= w_gnt_id;
  end
`endif

  assign w_issue = (r_state == S_IDLE) && w_gnt_vld &&
                   !pru_busy && !pru_done;

  always_comb begin
    for (int i = 0; i < NUM_REQ; i++) begin
      w_pop[i] = w_issue && (w_gnt_id == IW'(i));
    end
  end

  always_comb begin
    w_next = r_state;
    unique case (r_state)
      S_IDLE:      if (w_issue)   w_next = S_ISSUE;
      S_ISSUE:                    w_next = S_WAIT_DONE;
      S_WAIT_DONE: if (pru_done)  w_next = S_RELEASE;
      S_RELEASE:   if (!pru_done) w_next = S_IDLE;
      default:                    w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state   <= S_IDLE;
      r_gnt     <= '0;
      pru_start <= 1'b0;
      pru_cmd   <= '0;
      cmp_valid <= 1'b0;
      cmp_id    <= '0;
    end else begin
      r_state   <= w_next;
      pru_start <= (w_next == S_WAIT_DONE);
      cmp_valid <= (r_state == S_WAIT_DONE) && pru_done;
      if (w_issue) begin
        pru_cmd <= w_head[w_gnt_id];
        r_gnt   <= w_gnt_id;
      end
      if ((r_state == S_WAIT_DONE) && pru_done) cmp_id <= r_gnt;
    end
  end

endmodule

// File: tb/tb_pru_sched.sv
// Directed scoreboard bench for pru_sched with a simple PRU model.
// Expected issue order is queued as commands are driven.
module tb_pru_sched;
  import pru_pkg::*;

  localparam int NUM_REQ = 2;
  localparam int DEPTH   = 4;
  localparam int IW      = 1;

  typedef struct {
    int       id;
    pru_cmd_t cmd;
  } exp_t;

  logic                   clk = 1'b0;
  logic                   rst = 1'b1;
  logic [NUM_REQ-1:0]     req_valid = '0;
  pru_cmd_t [NUM_REQ-1:0] req_cmd = '0;
  logic [NUM_REQ-1:0]     req_ready;
  logic                   pru_start;
  pru_cmd_t               pru_cmd;
  logic                   pru_busy = 1'b1;
  logic                   pru_done = 1'b0;
  logic                   cmp_valid;
  logic [IW-1:0]          cmp_id;
  logic                   sched_busy;

  exp_t exp_q[$];
  int   id_q[$];
  int   checks = 0;
  int   failures = 0;
  int   ncmp = 0;
  int   lat = 80;
  bit   model_en = 1'b0;

  pru_sched #(.NUM_REQ(NUM_REQ), .DEPTH(DEPTH)) dut (
    .clk        (clk),
    .rst        (rst),
    .req_valid  (req_valid),
    .req_cmd    (req_cmd),
    .req_ready  (req_ready),
    .pru_start  (pru_start),
    .pru_cmd    (pru_cmd),
    .pru_busy   (pru_busy),
    .pru_done   (pru_done),
    .cmp_valid  (cmp_valid),
    .cmp_id     (cmp_id),
    .sched_busy (sched_busy)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [74:0] obs,
                       input logic [74:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic pru_cmd_t mk(input int row, input int col,
                                  input int w, input int h,
                                  input int color, input logic [1:0] shp,
                                  input logic sub, input int addr);
    pru_cmd_t c;
    c.color         = 2'(color);
    c.row           = 10'(row);
    c.col           = 9'(col);
    c.width         = 10'(w);
    c.height_radius = 9'(h);
    c.shape_select  = shp;
    c.subtract      = sub;
    c.bitmap_addr   = 32'(addr);
    return c;
  endfunction

  function automatic exp_t ex(input int id, input pru_cmd_t c);
    exp_t e;
    e.id  = id;
    e.cmd = c;
    return e;
  endfunction

  task automatic push(input int r, input pru_cmd_t c);
    int n;
    n = 0;
    @(negedge clk);
    req_valid[r] = 1'b1;
    req_cmd[r]   = c;
    while (!req_ready[r] && n < 500) begin
      @(negedge clk);
      n++;
    end
    checks++;
    assert (req_ready[r]) else begin
      failures++;
      $error("FAIL push_timeout observed=%0d expected=1", req_ready[r]);
    end
    @(posedge clk);
    #1;
    req_valid[r] = 1'b0;
  endtask

  task automatic wait_cmp(input string tag);
    int n;
    n = 0;
    @(negedge clk);
    while (!cmp_valid && n < 2000) begin
      @(negedge clk);
      n++;
    end
    check(tag, 75'(cmp_valid), 75'(1));
  endtask

  task automatic wait_idle(input string tag);
    int n;
    n = 0;
    @(negedge clk);
    while (sched_busy && n < 5000) begin
      @(negedge clk);
      n++;
    end
    check(tag, 75'(sched_busy), 75'(0));
  endtask

  // PRU model: done after lat cycles of start, dropped once start falls.
  initial begin
    int cnt;
    cnt = 0;
    forever begin
      @(negedge clk);
      if (rst || !model_en) begin
        cnt = 0;
        if (rst) pru_done = 1'b0;
      end else if (pru_start && !pru_done) begin
        cnt++;
        if (cnt >= lat) begin
          pru_done = 1'b1;
          cnt = 0;
        end
      end else if (!pru_start && pru_done) begin
        pru_done = 1'b0;
      end
    end
  end

  // Issue and completion monitor against the scoreboard.
  initial begin
    bit   ps;
    bit   pc;
    exp_t e;
    ps = 1'b0;
    pc = 1'b0;
    forever begin
      @(negedge clk);
      if (!rst) begin
        if (pru_start && !ps) begin
          checks++;
          assert (exp_q.size() > 0) else begin
            failures++;
            $error("FAIL issue_unexp observed=start expected=idle");
          end
          if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            check("issue_cmd", pru_cmd, e.cmd);
            id_q.push_back(e.id);
          end
        end
        if (cmp_valid) begin
          ncmp++;
          checks++;
          assert (id_q.size() > 0) else begin
            failures++;
            $error("FAIL cmp_unexp observed=%0d expected=none", cmp_id);
          end
          if (id_q.size() > 0)
            check("cmp_id", 75'(cmp_id), 75'(id_q.pop_front()));
          check("cmp_pulse", 75'(pc), 75'(0));
        end
      end
      ps = pru_start;
      pc = cmp_valid;
    end
  end

  initial begin
    #1000000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    pru_cmd_t c;
    pru_cmd_t a [4];
    pru_cmd_t b [4];
    pru_cmd_t d [5];
    pru_cmd_t f [5];
    int       base;

    repeat (2) @(negedge clk);
    check("rst_ready", 75'(req_ready), 75'(2'b11));
    check("rst_start", 75'(pru_start), 75'(0));
    check("rst_cmd", pru_cmd, 75'(0));
    check("rst_cmpv", 75'(cmp_valid), 75'(0));
    check("rst_cmpid", 75'(cmp_id), 75'(0));
    check("rst_sbusy", 75'(sched_busy), 75'(0));
    rst = 1'b0;

    // PRU busy after its own reset holds the scheduler.
    model_en = 1'b1;
    lat = 80;
    c = mk(5, 5, 10, 8, 2, SHAPE_RECT, 1'b0, 32'h1000);
    exp_q.push_back(ex(0, c));
    push(0, c);
    repeat (2500) @(negedge clk);
    check("busy_hold_start", 75'(pru_start), 75'(0));
    check("busy_hold_sbusy", 75'(sched_busy), 75'(1));
    pru_busy = 1'b0;
    @(negedge clk);
    check("start_lat1", 75'(pru_start), 75'(0));
    @(negedge clk);
    check("start_lat2", 75'(pru_start), 75'(1));
    check("start_fields", pru_cmd, c);
    wait_cmp("single_cmp");
    check("start_fall", 75'(pru_start), 75'(0));
    wait_idle("single_idle");
    check("single_count", 75'(ncmp), 75'(1));

    // Both FIFOs filled while PRU busy, then drained.
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    pru_busy = 1'b1;
    lat = 3;
    base = ncmp;
    for (int i = 0; i < 4; i++) begin
      a[i] = mk(10 + i, 20 + i, 30, 12, 1, SHAPE_CIRCLE, 1'b0, 32'h2000 + i);
      b[i] = mk(100 + i, 200 + i, 40, 7, 3, SHAPE_RECT, 1'b1, 32'h3000 + i);
    end
`ifdef PRU_SCHED_PRIO_EN
    for (int i = 0; i < 4; i++) exp_q.push_back(ex(0, a[i]));
    for (int i = 0; i < 4; i++) exp_q.push_back(ex(1, b[i]));
`else
    for (int i = 0; i < 4; i++) begin
      exp_q.push_back(ex(0, a[i]));
      exp_q.push_back(ex(1, b[i]));
    end
`endif
    for (int i = 0; i < 4; i++) push(0, a[i]);
    for (int i = 0; i < 4; i++) push(1, b[i]);
    @(negedge clk);
    check("both_full", 75'(req_ready), 75'(2'b00));
    pru_busy = 1'b0;
    wait_idle("arb_idle");
    check("arb_count", 75'(ncmp - base), 75'(8));

    // Requester 1 overflow with PRU stalled; requester 0 unaffected.
    pru_busy = 1'b1;
    base = ncmp;
    for (int i = 0; i < 5; i++)
      d[i] = mk(300 + i, 50 + i, 5, 5, 0, SHAPE_RECT, 1'b0, 32'h4000 + i);
    c = mk(1, 2, 3, 4, 1, SHAPE_CIRCLE, 1'b1, 32'h5000);
    exp_q.push_back(ex(0, c));
    for (int i = 0; i < 5; i++) exp_q.push_back(ex(1, d[i]));
    for (int i = 0; i < 4; i++) push(1, d[i]);
    @(negedge clk);
    check("ovf_full", 75'(req_ready), 75'(2'b01));
    req_valid[1] = 1'b1;
    req_cmd[1]   = d[4];
    repeat (10) @(negedge clk);
    check("ovf_held", 75'(req_ready), 75'(2'b01));
    push(0, c);
    @(negedge clk);
    check("ovf_req0_ok", 75'(req_ready), 75'(2'b01));
    pru_busy = 1'b0;
    begin
      int n;
      n = 0;
      while (!req_ready[1] && n < 500) begin
        @(negedge clk);
        n++;
      end
      check("ovf_drain", 75'(req_ready[1]), 75'(1));
    end
    @(posedge clk);
    #1;
    req_valid[1] = 1'b0;
    wait_idle("ovf_idle");
    check("ovf_count", 75'(ncmp - base), 75'(6));

    // Push and pop on the same edge keep the count.
    pru_busy = 1'b1;
    lat = 80;
    base = ncmp;
    for (int i = 0; i < 5; i++) begin
      f[i] = mk(400 + i, 300 + i, 64, 32, 2, SHAPE_RECT, 1'b0, 32'h6000 + i);
      exp_q.push_back(ex(0, f[i]));
    end
    push(0, f[0]);
    push(0, f[1]);
    @(negedge clk);
    pru_busy     = 1'b0;
    req_valid[0] = 1'b1;
    req_cmd[0]   = f[2];
    @(posedge clk);
    #1;
    req_valid[0] = 1'b0;
    push(0, f[3]);
    push(0, f[4]);
    @(negedge clk);
    check("pp_count", 75'(req_ready), 75'(2'b10));
    wait_idle("pp_idle");
    check("pp_done", 75'(ncmp - base), 75'(5));
    check("sb_empty", 75'(exp_q.size()), 75'(0));

    // Reset while a command is in flight.
    model_en = 1'b0;
    base = ncmp;
    c = mk(7, 8, 9, 10, 3, SHAPE_CIRCLE, 1'b1, 32'h7000);
    exp_q.push_back(ex(0, c));
    push(0, c);
    push(0, c);
    begin
      int n;
      n = 0;
      while (!pru_start && n < 100) begin
        @(negedge clk);
        n++;
      end
      check("rm_start", 75'(pru_start), 75'(1));
    end
    repeat (3) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    check("rm_start0", 75'(pru_start), 75'(0));
    check("rm_sbusy", 75'(sched_busy), 75'(0));
    check("rm_ready", 75'(req_ready), 75'(2'b11));
    check("rm_cmpv", 75'(cmp_valid), 75'(0));
    exp_q.delete();
    id_q.delete();
    rst = 1'b0;
    repeat (20) @(negedge clk);
    check("rm_no_cmp", 75'(ncmp - base), 75'(0));
    check("rm_idle", 75'(sched_busy), 75'(0));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
